// File: rtl/kmkz_writeback.sv
// Kamikaze-uRV writeback stage: result select, load alignment, bounded load wait, RF write, bypass.
// Optional retired-instruction counter enabled by defining KMKZ_WB_RETIRE_COUNT_EN.
module kmkz_writeback #(
  parameter int unsigned MEM_TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        w_stall_i,
  output logic        w_stall_req_o,
  input  logic [2:0]  x_fun_i,
  input  logic        x_load_i,
  input  logic        x_store_i,
  input  logic        x_valid_i,
  input  logic [4:0]  x_rd_i,
  input  logic [31:0] x_rd_value_i,
  input  logic        x_rd_write_i,
  input  logic [31:0] x_dm_addr_i,
  input  logic [1:0]  x_rd_source_i,
  input  logic [31:0] x_shifter_rd_value_i,
  input  logic [31:0] x_multiply_rd_value_i,
  input  logic [31:0] dm_data_l_i,
  input  logic        dm_load_done_i,
  output logic [4:0]  rf_rd_o,
  output logic [31:0] rf_rd_value_o,
  output logic        rf_rd_write_o,
  output logic [4:0]  w_bypass_rd_o,
  output logic [31:0] w_bypass_rd_value_o,
  output logic        w_bypass_rd_write_o,
`ifdef KMKZ_WB_RETIRE_COUNT_EN
  output logic [63:0] w_retired_o,
`endif
  output logic        w_bus_error_o
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StHold = 2'd2;

  localparam logic [7:0] TermCount = 8'(MEM_TIMEOUT - 1);

  logic [1:0]  state_q, state_d;
  logic [7:0]  timer_q, timer_d;
  logic [31:0] load_buf_q, load_buf_d;
  logic        bus_error_d;
  logic        load_done;
  logic        is_load;
  logic [31:0] load_src;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_value;
  logic        unused_addr;

  assign unused_addr = ^x_dm_addr_i[31:2];

  // A store never waits for load data, even if x_load_i were also set.
  assign is_load = x_valid_i & x_load_i & ~x_store_i;

  always_comb begin
    load_src = (state_q == StHold) ? load_buf_q : dm_data_l_i;
    unique case (x_dm_addr_i[1:0])
      2'd0:    load_byte = load_src[7:0];
      2'd1:    load_byte = load_src[15:8];
      2'd2:    load_byte = load_src[23:16];
      default: load_byte = load_src[31:24];
    endcase
    load_half = x_dm_addr_i[1] ? load_src[31:16] : load_src[15:0];
    case (x_fun_i)
      3'b000:  load_value = {{24{load_byte[7]}}, load_byte};
      3'b001:  load_value = {{16{load_half[15]}}, load_half};
      3'b100:  load_value = {24'd0, load_byte};
      3'b101:  load_value = {16'd0, load_half};
      default: load_value = load_src;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    load_buf_d    = load_buf_q;
    bus_error_d   = 1'b0;
    load_done     = 1'b0;
    w_stall_req_o = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (is_load) begin
          if (dm_load_done_i) begin
            if (w_stall_i) begin
              state_d    = StHold;
              load_buf_d = dm_data_l_i;
            end else begin
              load_done = 1'b1;
            end
          end else begin
            w_stall_req_o = 1'b1;
            state_d       = StWait;
            timer_d       = 8'd0;
          end
        end
      end
      StWait: begin
        if (dm_load_done_i) begin
          if (w_stall_i) begin
            state_d    = StHold;
            load_buf_d = dm_data_l_i;
          end else begin
            load_done = 1'b1;
            state_d   = StIdle;
          end
        end else if (timer_q == TermCount) begin
          // Release the stall on the abandon cycle so the load retires instead of reissuing.
          state_d     = StIdle;
          bus_error_d = 1'b1;
        end else begin
          w_stall_req_o = 1'b1;
          timer_d       = timer_q + 8'd1;
        end
      end
      StHold: begin
        if (!w_stall_i) begin
          load_done = 1'b1;
          state_d   = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    rf_rd_o = x_rd_i;
    unique case (x_rd_source_i)
      2'b00:   rf_rd_value_o = x_rd_value_i;
      2'b01:   rf_rd_value_o = x_shifter_rd_value_i;
      2'b10:   rf_rd_value_o = x_multiply_rd_value_i;
      default: rf_rd_value_o = load_value;
    endcase
    rf_rd_write_o = rst_i & x_valid_i & x_rd_write_i & ~w_stall_i & (x_rd_i != 5'd0) &
                    (~is_load | load_done);
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q             <= StIdle;
      timer_q             <= 8'd0;
      load_buf_q          <= 32'd0;
      w_bus_error_o       <= 1'b0;
      w_bypass_rd_o       <= 5'd0;
      w_bypass_rd_value_o <= 32'd0;
      w_bypass_rd_write_o <= 1'b0;
    end else begin
      state_q             <= state_d;
      timer_q             <= timer_d;
      load_buf_q          <= load_buf_d;
      w_bus_error_o       <= bus_error_d;
      w_bypass_rd_write_o <= rf_rd_write_o;
      if (rf_rd_write_o) begin
        w_bypass_rd_o       <= rf_rd_o;
        w_bypass_rd_value_o <= rf_rd_value_o;
      end
    end
  end

`ifdef KMKZ_WB_RETIRE_COUNT_EN
  logic retire;
  assign retire = rf_rd_write_o | (rst_i & x_valid_i & ~is_load & ~w_stall_i);

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      w_retired_o <= 64'd0;
    end else if (retire) begin
      w_retired_o <= w_retired_o + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_kmkz_writeback.sv
// Directed bench for kmkz_writeback built with MEM_TIMEOUT=4; checks w_retired_o when
// KMKZ_WB_RETIRE_COUNT_EN is defined.
module tb_kmkz_writeback;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        w_stall_i;
  logic        w_stall_req_o;
  logic [2:0]  x_fun_i;
  logic        x_load_i;
  logic        x_store_i;
  logic        x_valid_i;
  logic [4:0]  x_rd_i;
  logic [31:0] x_rd_value_i;
  logic        x_rd_write_i;
  logic [31:0] x_dm_addr_i;
  logic [1:0]  x_rd_source_i;
  logic [31:0] x_shifter_rd_value_i;
  logic [31:0] x_multiply_rd_value_i;
  logic [31:0] dm_data_l_i;
  logic        dm_load_done_i;
  logic [4:0]  rf_rd_o;
  logic [31:0] rf_rd_value_o;
  logic        rf_rd_write_o;
  logic [4:0]  w_bypass_rd_o;
  logic [31:0] w_bypass_rd_value_o;
  logic        w_bypass_rd_write_o;
  logic        w_bus_error_o;
`ifdef KMKZ_WB_RETIRE_COUNT_EN
  logic [63:0] w_retired_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  kmkz_writeback #(.MEM_TIMEOUT(4)) dut (
    .clk_i                 (clk_i),
    .rst_i                 (rst_i),
    .w_stall_i             (w_stall_i),
    .w_stall_req_o         (w_stall_req_o),
    .x_fun_i               (x_fun_i),
    .x_load_i              (x_load_i),
    .x_store_i             (x_store_i),
    .x_valid_i             (x_valid_i),
    .x_rd_i                (x_rd_i),
    .x_rd_value_i          (x_rd_value_i),
    .x_rd_write_i          (x_rd_write_i),
    .x_dm_addr_i           (x_dm_addr_i),
    .x_rd_source_i         (x_rd_source_i),
    .x_shifter_rd_value_i  (x_shifter_rd_value_i),
    .x_multiply_rd_value_i (x_multiply_rd_value_i),
    .dm_data_l_i           (dm_data_l_i),
    .dm_load_done_i        (dm_load_done_i),
    .rf_rd_o               (rf_rd_o),
    .rf_rd_value_o         (rf_rd_value_o),
    .rf_rd_write_o         (rf_rd_write_o),
    .w_bypass_rd_o         (w_bypass_rd_o),
    .w_bypass_rd_value_o   (w_bypass_rd_value_o),
    .w_bypass_rd_write_o   (w_bypass_rd_write_o),
`ifdef KMKZ_WB_RETIRE_COUNT_EN
    .w_retired_o           (w_retired_o),
`endif
    .w_bus_error_o         (w_bus_error_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle_inputs();
    x_valid_i = 1'b0; x_load_i = 1'b0; x_store_i = 1'b0; x_rd_write_i = 1'b0;
    x_rd_i = 5'd0; x_rd_source_i = 2'b00; x_fun_i = 3'b010; x_dm_addr_i = 32'd0;
    dm_load_done_i = 1'b0; w_stall_i = 1'b0;
  endtask

  task automatic alu(input logic [4:0] rd, input logic [31:0] val);
    idle_inputs();
    x_valid_i = 1'b1; x_rd_write_i = 1'b1; x_rd_i = rd; x_rd_value_i = val;
  endtask

  task automatic load(input logic [4:0] rd, input logic [2:0] fun, input logic [31:0] addr);
    idle_inputs();
    x_valid_i = 1'b1; x_load_i = 1'b1; x_rd_write_i = 1'b1; x_rd_i = rd;
    x_rd_source_i = 2'b11; x_fun_i = fun; x_dm_addr_i = addr;
  endtask

  initial begin
    idle_inputs();
    x_rd_value_i = 32'd0; x_shifter_rd_value_i = 32'hAAAA_5555;
    x_multiply_rd_value_i = 32'h0BAD_F00D; dm_data_l_i = 32'd0;
    rst_i = 1'b0;
    #1;

    // Reset: write forced low even with a valid ALU op presented
    alu(5'd5, 32'h1234);
    #1;
    check("rst_write", rf_rd_write_o, 0);
    tick(); tick();
    check("rst_byp_rd", w_bypass_rd_o, 0);
    check("rst_byp_val", w_bypass_rd_value_o, 0);
    check("rst_byp_wr", w_bypass_rd_write_o, 0);
    check("rst_buserr", w_bus_error_o, 0);
    idle_inputs();
    rst_i = 1'b1;
    tick();

    // ALU op and bypass
    alu(5'd5, 32'h1234);
    #1;
    check("alu_write", rf_rd_write_o, 1);
    check("alu_rd", rf_rd_o, 5);
    check("alu_val", rf_rd_value_o, 32'h1234);
    tick();
    idle_inputs();
    check("byp_rd", w_bypass_rd_o, 5);
    check("byp_val", w_bypass_rd_value_o, 32'h1234);
    check("byp_wr", w_bypass_rd_write_o, 1);
    tick();
    check("byp_wr_drop", w_bypass_rd_write_o, 0);
    check("byp_rd_keep", w_bypass_rd_o, 5);

    // Shifter / multiplier sources, stalled ALU
    alu(5'd6, 32'h0); x_rd_source_i = 2'b01;
    #1;
    check("shift_val", rf_rd_value_o, 32'hAAAA_5555);
    tick();
    alu(5'd7, 32'h0); x_rd_source_i = 2'b10;
    #1;
    check("mul_val", rf_rd_value_o, 32'h0BAD_F00D);
    tick();
    alu(5'd7, 32'h1); w_stall_i = 1'b1;
    #1;
    check("stall_nowrite", rf_rd_write_o, 0);
    tick();

    // Zero-wait loads with extraction
    dm_data_l_i = 32'h80FF_FF00;
    load(5'd8, 3'b000, 32'h1000_0003); dm_load_done_i = 1'b1;
    #1;
    check("lb_val", rf_rd_value_o, 32'hFFFF_FF80);
    check("lb_write", rf_rd_write_o, 1);
    check("lb_stallreq", w_stall_req_o, 0);
    tick();
    load(5'd8, 3'b101, 32'h1000_0002); dm_load_done_i = 1'b1;
    #1;
    check("lhu_val", rf_rd_value_o, 32'h0000_80FF);
    tick();
    load(5'd8, 3'b001, 32'h1000_0002); dm_load_done_i = 1'b1;
    #1;
    check("lh_val", rf_rd_value_o, 32'hFFFF_80FF);
    tick();
    load(5'd8, 3'b100, 32'h1000_0001); dm_load_done_i = 1'b1;
    #1;
    check("lbu_val", rf_rd_value_o, 32'h0000_00FF);
    tick();
    load(5'd8, 3'b010, 32'h1000_0000); dm_load_done_i = 1'b1;
    #1;
    check("lw_val", rf_rd_value_o, 32'h80FF_FF00);
    tick();

    // Load completing 3 cycles late
    load(5'd9, 3'b010, 32'h0);
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("late_stall%0d", i), w_stall_req_o, 1);
      check($sformatf("late_nowr%0d", i), rf_rd_write_o, 0);
      tick();
    end
    dm_data_l_i = 32'hCAFE_BABE; dm_load_done_i = 1'b1;
    #1;
    check("late_stall_end", w_stall_req_o, 0);
    check("late_write", rf_rd_write_o, 1);
    check("late_val", rf_rd_value_o, 32'hCAFE_BABE);
    tick();

    // Done during external stall -> HOLD, then write latched value
    load(5'd10, 3'b000, 32'h0); dm_data_l_i = 32'h0000_007F;
    dm_load_done_i = 1'b1; w_stall_i = 1'b1;
    #1;
    check("hold_in_nowr", rf_rd_write_o, 0);
    tick();
    dm_load_done_i = 1'b0; dm_data_l_i = 32'hFFFF_FFFF;
    #1;
    check("hold_nowr", rf_rd_write_o, 0);
    check("hold_stallreq", w_stall_req_o, 0);
    tick();
    w_stall_i = 1'b0;
    #1;
    check("hold_write", rf_rd_write_o, 1);
    check("hold_val", rf_rd_value_o, 32'h0000_007F);
    tick();

    // Timeout with MEM_TIMEOUT=4: 4 stall cycles, then abandon cycle
    load(5'd11, 3'b010, 32'h0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check($sformatf("to_stall%0d", i), w_stall_req_o, (i < 4) ? 1 : 0);
      check($sformatf("to_nowr%0d", i), rf_rd_write_o, 0);
      check($sformatf("to_noerr%0d", i), w_bus_error_o, 0);
      tick();
    end
    idle_inputs();
    #1;
    check("to_buserr", w_bus_error_o, 1);
    tick();
    check("to_buserr_once", w_bus_error_o, 0);

    // rd=0 never written
    alu(5'd0, 32'hDEAD);
    #1;
    check("rd0_nowrite", rf_rd_write_o, 0);
    tick();

    // Done on the terminal-count cycle wins
    load(5'd12, 3'b010, 32'h0);
    for (int i = 0; i < 4; i++) tick();
    dm_data_l_i = 32'h1357_9BDF; dm_load_done_i = 1'b1;
    #1;
    check("tc_write", rf_rd_write_o, 1);
    check("tc_val", rf_rd_value_o, 32'h1357_9BDF);
    tick();
    idle_inputs();
    #1;
    check("tc_noerr", w_bus_error_o, 0);

    // Reset in WAIT drops the load
    load(5'd13, 3'b010, 32'h0);
    tick(); tick();
    idle_inputs();
    rst_i = 1'b0;
    #1;
    check("rstw_byp_rd", w_bypass_rd_o, 0);
    check("rstw_byp_val", w_bypass_rd_value_o, 0);
    tick();
    rst_i = 1'b1;
    dm_load_done_i = 1'b1;
    #1;
    check("rstw_idle_stall", w_stall_req_o, 0);
    check("rstw_nowrite", rf_rd_write_o, 0);
    tick();
    check("rstw_byp_wr", w_bypass_rd_write_o, 0);
    check("rstw_byp_val2", w_bypass_rd_value_o, 0);

`ifdef KMKZ_WB_RETIRE_COUNT_EN
    for (int i = 0; i < 3; i++) begin
      alu(5'(i + 1), 32'(i));
      tick();
    end
    load(5'd14, 3'b010, 32'h0);
    for (int i = 0; i < 5; i++) tick();
    idle_inputs();
    tick();
    check("retired", w_retired_o, 64'd3);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/kmkz_writeback.md
Name: kmkz_writeback

Overview:
- Writeback stage of the Kamikaze-uRV pipeline; consumes the X/W pipeline registers of the execute stage.
- Selects the result source: ALU/CSR value, shifter, multiplier or aligned/extended load data.
- Waits for load data with a bounded timeout and drives the register-file write port.
- Provides a registered one-cycle bypass of the last written register for execute-stage forwarding.

Parameters:
- MEM_TIMEOUT, 255: cycles spent in WAIT before a load is abandoned (1..255; counter is 8 bits).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; asynchronous, active-low
- w_stall_i  in  1  stall from sources other than this block
- w_stall_req_o  out  1  stall request while load data is outstanding
- x_fun_i  in  3  funct3: B=000 H=001 L=010 BU=100 HU=101
- x_load_i  in  1  instruction is a load
- x_store_i  in  1  instruction is a store
- x_valid_i  in  1  instruction valid
- x_rd_i  in  5  destination register
- x_rd_value_i  in  32  ALU/CSR result
- x_rd_write_i  in  1  instruction writes rd
- x_dm_addr_i  in  32  load/store address
- x_rd_source_i  in  2  00 ALU/CSR, 01 shifter, 10 multiply, 11 load
- x_shifter_rd_value_i  in  32  shifter result
- x_multiply_rd_value_i  in  32  multiplier result
- dm_data_l_i  in  32  load data
- dm_load_done_i  in  1  load data valid this cycle
- rf_rd_o  out  5  RF write address
- rf_rd_value_o  out  32  RF write data
- rf_rd_write_o  out  1  RF write enable
- w_bypass_rd_o  out  5  registered last-written rd
- w_bypass_rd_value_o  out  32  registered last-written value
- w_bypass_rd_write_o  out  1  bypass valid
- w_bus_error_o  out  1  one-cycle pulse on load timeout

Behaviour:
- Load extraction, byte lane from x_dm_addr_i[1:0]:
  - B/BU select the addressed byte; H/HU select the half given by addr[1].
  - L passes the full word.
  - B and H sign-extend; BU and HU zero-extend.
  - Data comes from dm_data_l_i, or from load_buf when in HOLD.
- FSM states: IDLE, WAIT, HOLD.
  - IDLE, valid load, no dm_load_done_i: w_stall_req_o=1 (combinational), go to WAIT, timer=0.
  - IDLE, valid load, dm_load_done_i, w_stall_i=0: write in the same cycle, stay IDLE, zero-wait.
  - IDLE or WAIT, dm_load_done_i with w_stall_i=1: latch data into load_buf, go to HOLD.
  - WAIT: w_stall_req_o=1; timer increments each cycle.
  - WAIT, dm_load_done_i with w_stall_i=0: write, go to IDLE.
  - WAIT, timer reaches MEM_TIMEOUT-1 without done: no RF write, w_bus_error_o=1 next cycle, go to IDLE.
  - dm_load_done_i on the terminal-count cycle: done wins, no error.
  - HOLD: w_stall_req_o=0; dm_data_l_i ignored; when w_stall_i=0, write load_buf and go to IDLE.
- rf_rd_write_o = x_valid_i & x_rd_write_i & !w_stall_i & (x_rd_i!=0) & (non-load, or load completing this cycle).
  - Forced 0 while rst_i low. Combinational.
- Stores retire without waiting; no RF write.
- Bypass registers update on every cycle with rf_rd_write_o=1 and take the written rd/value.
  - w_bypass_rd_write_o = registered rf_rd_write_o; it deasserts the cycle after a non-write cycle.
- Reset values:
  - Outputs: bypass rd/value/write = 0, w_bus_error_o = 0.
  - Internal: state IDLE, timer 0, load_buf 0.
- Reset mid-WAIT/HOLD: pending load dropped, no write after reset release.
- x_valid_i=0: nothing written; FSM held in IDLE if already IDLE.

Optional Feature:
- Macro: KMKZ_WB_RETIRE_COUNT_EN.
- When defined, adds output w_retired_o (64 bits), reset 0.
  - Increments by 1 on each cycle that retires a valid instruction: any RF write, a non-writing valid non-load with w_stall_i=0, or a store.
  - Timed-out loads are not counted; the counter wraps at 2^64.
- When undefined, the port and counter are absent.

Test Plan:
- ALU op: x_rd_source=00, rd=5, value=0x1234 -> same cycle rf_rd_write_o=1, rf_rd_o=5, value 0x1234; next cycle bypass rd=5, value 0x1234, write=1.
- LB at addr 0x...3 with dm_data_l_i=0x80FF_FF00 and done same cycle -> 0xFFFF_FF80; LHU at addr 0x...2 -> 0x0000_80FF; no stall.
- Load with done 3 cycles late -> w_stall_req_o=1 for 3 cycles, write on the 4th cycle.
- Done arrives while w_stall_i=1 -> HOLD; w_stall_i drops 2 cycles later -> write of the latched value.
- MEM_TIMEOUT=4, no done -> stall 4 cycles, w_bus_error_o pulses once, rf_rd_write_o never 1; rd=0 write with value 0xDEAD -> rf_rd_write_o=0.
- Reset asserted in WAIT -> after release: IDLE, no write, all bypass outputs 0; with KMKZ_WB_RETIRE_COUNT_EN, 3 ALU ops + 1 timed-out load -> w_retired_o=3.
